// File: rtl/open_loop_pkg.sv
// Shared types and helpers for the soft-start open-loop DPWM.
package open_loop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2
    } ss_state_t;

    function automatic int unsigned add_sat(
        input int unsigned a,
        input int unsigned b,
        input int unsigned lim
    );
        int unsigned s;
        s = a + b;
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/dpwm_core.sv
// Period counter, shadowed dead-times and registered complementary gate compare.
module dpwm_core #(
    parameter int CNT_W  = 11,
    parameter int PERIOD = 1000,
    parameter int DT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] ton_eff,
    input  logic [DT_W-1:0]  dt1,
    input  logic [DT_W-1:0]  dt2,
    output logic             wrap,
    output logic             o_c1,
    output logic             o_c2,
    output logic             o_period_start
);

    localparam int W = CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
    localparam logic [W-1:0] PER = W'(PERIOD);

    logic [CNT_W-1:0] cnt;
    logic [DT_W-1:0]  dt1_sh;
    logic [DT_W-1:0]  dt2_sh;
    logic [W-1:0]     cnt_x;
    logic [W-1:0]     ton_x;
    logic [W-1:0]     dt1_x;
    logic [W-1:0]     dt2_x;
    logic             c1_next;
    logic             c2_next;

    // Widened compare so ton_eff + dt2 never wraps; ton_eff clamps at PERIOD.
    always_comb begin
        cnt_x   = W'(cnt);
        ton_x   = (W'(ton_eff) > PER) ? PER : W'(ton_eff);
        dt1_x   = W'(dt1_sh);
        dt2_x   = W'(dt2_sh);
        c1_next = (cnt_x >= dt1_x) && (cnt_x < ton_x);
        c2_next = (cnt_x >= ton_x + dt2_x) && (cnt_x < PER);
    end

    assign wrap = run && (cnt == LAST);

    // While stopped the shadows follow the inputs, so start-up loads them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt            <= '0;
            dt1_sh         <= '0;
            dt2_sh         <= '0;
            o_c1           <= 1'b0;
            o_c2           <= 1'b0;
            o_period_start <= 1'b0;
        end else if (!run) begin
            cnt            <= '0;
            dt1_sh         <= dt1;
            dt2_sh         <= dt2;
            o_c1           <= 1'b0;
            o_c2           <= 1'b0;
            o_period_start <= 1'b0;
        end else begin
            o_c1           <= c1_next;
            o_c2           <= c2_next;
            o_period_start <= (cnt == '0);
            if (wrap) begin
                cnt    <= '0;
                dt1_sh <= dt1;
                dt2_sh <= dt2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/open_loop_ss.sv
// Open-loop half-bridge PWM with soft-start ramp of the applied on-time.
module open_loop_ss
    import open_loop_pkg::*;
#(
    parameter int CNT_W  = 11,
    parameter int PERIOD = 1000,
    parameter int DT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] i_ton,
    input  logic [DT_W-1:0]  i_dt1,
    input  logic [DT_W-1:0]  i_dt2,
    input  logic [CNT_W-1:0] i_ss_step,
    output logic             o_c1,
    output logic             o_c2,
    output logic             o_ss_done,
    output logic             o_period_start
);

    ss_state_t        state;
    logic [CNT_W-1:0] ton_eff;
    logic [CNT_W-1:0] ton_first;
    logic [CNT_W-1:0] ton_ramp;
    logic             run;
    logic             wrap;
    logic             direct;

    assign run       = enable && (state != IDLE);
    assign direct    = (i_ss_step == '0) || (i_ton == '0);
    assign ton_first = CNT_W'(add_sat(0, 32'(i_ss_step), 32'(i_ton)));
    assign ton_ramp  = CNT_W'(add_sat(32'(ton_eff), 32'(i_ss_step), 32'(i_ton)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ton_eff   <= '0;
            o_ss_done <= 1'b0;
        end else if (!enable) begin
            state     <= IDLE;
            ton_eff   <= '0;
            o_ss_done <= 1'b0;
        end else begin
            o_ss_done <= (state == RUN);
            unique case (state)
                IDLE: begin
                    if (direct) begin
                        state   <= RUN;
                        ton_eff <= i_ton;
                    end else begin
                        state   <= RAMP;
                        ton_eff <= ton_first;
                    end
                end
                // A target below the ramp value also lands here and ends the ramp.
                RAMP: begin
                    if (wrap) begin
                        ton_eff <= ton_ramp;
                        if (ton_ramp == i_ton) state <= RUN;
                    end
                end
                RUN: begin
                    if (wrap) ton_eff <= i_ton;
                end
                default: begin
                    state   <= IDLE;
                    ton_eff <= '0;
                end
            endcase
        end
    end

    dpwm_core #(
        .CNT_W (CNT_W),
        .PERIOD(PERIOD),
        .DT_W  (DT_W)
    ) u_core (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .ton_eff       (ton_eff),
        .dt1           (i_dt1),
        .dt2           (i_dt2),
        .wrap          (wrap),
        .o_c1          (o_c1),
        .o_c2          (o_c2),
        .o_period_start(o_period_start)
    );

endmodule

// File: tb/tb_open_loop_ss.sv
// Bench for open_loop_ss: directed scenarios plus randomized per-period model.
module tb_open_loop_ss;

    localparam int CNT_W  = 11;
    localparam int PERIOD = 100;
    localparam int DT_W   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable = 1'b0;
    logic [CNT_W-1:0] i_ton = '0;
    logic [DT_W-1:0]  i_dt1 = '0;
    logic [DT_W-1:0]  i_dt2 = '0;
    logic [CNT_W-1:0] i_ss_step = '0;
    logic             o_c1;
    logic             o_c2;
    logic             o_ss_done;
    logic             o_period_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    open_loop_ss #(
        .CNT_W (CNT_W),
        .PERIOD(PERIOD),
        .DT_W  (DT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .i_ton         (i_ton),
        .i_dt1         (i_dt1),
        .i_dt2         (i_dt2),
        .i_ss_step     (i_ss_step),
        .o_c1          (o_c1),
        .o_c2          (o_c2),
        .o_ss_done     (o_ss_done),
        .o_period_start(o_period_start)
    );

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (o_c1 && o_c2) begin
                errors++;
                $display("FAIL overlap: c1=%b c2=%b, required not both high", o_c1, o_c2);
            end
        end
    end

    function automatic bit exp_c1(int k, int ton, int dt1);
        return (k >= dt1) && (k < ton);
    endfunction

    function automatic bit exp_c2(int k, int ton, int dt2);
        return k >= ton + dt2;
    endfunction

    function automatic int min_i(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int c1_len(int ton, int dt1);
        int v;
        v = min_i(ton, PERIOD) - dt1;
        return (v > 0) ? v : 0;
    endfunction

    function automatic int c2_len(int ton, int dt2);
        int v;
        v = PERIOD - ton - dt2;
        return (v > 0) ? v : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * PERIOD && !ok; i++) begin
            step();
            if (o_period_start) ok = 1'b1;
        end
    endtask

    task automatic run_period(input int ton, input int dt1, input int dt2,
                              output int c1n, output int c2n,
                              output int bad, output bit done);
        c1n  = 0;
        c2n  = 0;
        bad  = 0;
        done = o_ss_done;
        for (int k = 0; k < PERIOD; k++) begin
            if (o_period_start !== (k == 0)) bad++;
            if (o_c1 !== exp_c1(k, ton, dt1) || o_c2 !== exp_c2(k, ton, dt2)) bad++;
            c1n += int'(o_c1);
            c2n += int'(o_c2);
            step();
        end
    endtask

    task automatic test_reset();
        int idle_bad;
        rst = 1'b0;
        enable = 1'b0;
        repeat (3) step();
        checks++;
        if ({o_c1, o_c2, o_ss_done, o_period_start} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 0000",
                     {o_c1, o_c2, o_ss_done, o_period_start});
        end
        rst = 1'b1;
        idle_bad = 0;
        repeat (20) begin
            step();
            if (o_period_start || o_c1 || o_c2 || o_ss_done) idle_bad++;
        end
        checks++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL idle_hold: %0d active cycles, required 0", idle_bad);
        end
    endtask

    task automatic test_ramp();
        int c1n, c2n, bad, ton;
        bit done, ok;
        i_ton = CNT_W'(40);
        i_dt1 = DT_W'(3);
        i_dt2 = DT_W'(5);
        i_ss_step = CNT_W'(10);
        enable = 1'b1;
        sync_start(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ramp_start: period_start seen=%0b, required 1", ok);
        end
        for (int n = 1; n <= 5; n++) begin
            ton = min_i(n * 10, 40);
            run_period(ton, 3, 5, c1n, c2n, bad, done);
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL ramp_wave p%0d: %0d bad cycles, required 0", n, bad);
            end
            checks++;
            if (c1n != c1_len(ton, 3) || c2n != c2_len(ton, 5)) begin
                errors++;
                $display("FAIL ramp_len p%0d: c1=%0d c2=%0d, required c1=%0d c2=%0d",
                         n, c1n, c2n, c1_len(ton, 3), c2_len(ton, 5));
            end
            checks++;
            if (done !== (n >= 4)) begin
                errors++;
                $display("FAIL ramp_done p%0d: got %b, required %b", n, done, n >= 4);
            end
        end
    endtask

    task automatic test_mid_change();
        int c1n, c2n, bad;
        bit done;
        c1n = 0;
        c2n = 0;
        bad = 0;
        for (int k = 0; k < PERIOD; k++) begin
            if (k == 49) i_ton = CNT_W'(60);
            if (o_c1 !== exp_c1(k, 40, 3) || o_c2 !== exp_c2(k, 40, 5)) bad++;
            c1n += int'(o_c1);
            c2n += int'(o_c2);
            step();
        end
        checks++;
        if (bad != 0 || c1n != 37 || c2n != 55) begin
            errors++;
            $display("FAIL mid_same_period: bad=%0d c1=%0d c2=%0d, required 0/37/55",
                     bad, c1n, c2n);
        end
        run_period(60, 3, 5, c1n, c2n, bad, done);
        checks++;
        if (bad != 0 || c1n != 57 || c2n != 35) begin
            errors++;
            $display("FAIL mid_next_period: bad=%0d c1=%0d c2=%0d, required 0/57/35",
                     bad, c1n, c2n);
        end
    endtask

    task automatic test_disable();
        int c1n, c2n, bad, quiet_bad;
        bit done, ok, pre;
        enable = 1'b0;
        i_ton = CNT_W'(40);
        i_ss_step = CNT_W'(10);
        repeat (3) step();
        checks++;
        if ({o_c1, o_c2, o_ss_done} !== 3'b000) begin
            errors++;
            $display("FAIL disable_idle: got %b, required 000", {o_c1, o_c2, o_ss_done});
        end
        enable = 1'b1;
        sync_start(ok);
        repeat (19) step();
        pre = o_c2;
        enable = 1'b0;
        step();
        checks++;
        if (!ok || pre !== 1'b1 || o_c1 !== 1'b0 || o_c2 !== 1'b0) begin
            errors++;
            $display("FAIL disable_latency: start=%b c2_before=%b c1=%b c2=%b, required 1 1 0 0",
                     ok, pre, o_c1, o_c2);
        end
        quiet_bad = 0;
        repeat (5) begin
            step();
            if (o_c1 || o_c2 || o_period_start) quiet_bad++;
        end
        checks++;
        if (quiet_bad != 0) begin
            errors++;
            $display("FAIL disable_quiet: %0d active cycles, required 0", quiet_bad);
        end
        enable = 1'b1;
        sync_start(ok);
        run_period(10, 3, 5, c1n, c2n, bad, done);
        checks++;
        if (!ok || bad != 0 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_p1: start=%b bad=%0d done=%b, required 1 0 0", ok, bad, done);
        end
        run_period(20, 3, 5, c1n, c2n, bad, done);
        checks++;
        if (bad != 0 || c1n != 17) begin
            errors++;
            $display("FAIL restart_p2: bad=%0d c1=%0d, required 0 17", bad, c1n);
        end
    endtask

    task automatic test_saturation();
        int c1n, c2n, bad;
        bit done, ok;
        enable = 1'b0;
        step();
        i_ton = CNT_W'(95);
        i_dt1 = DT_W'(3);
        i_dt2 = DT_W'(5);
        i_ss_step = '0;
        enable = 1'b1;
        sync_start(ok);
        for (int n = 1; n <= 2; n++) begin
            run_period(95, 3, 5, c1n, c2n, bad, done);
            checks++;
            if (!ok || bad != 0 || c1n != 92 || c2n != 0 || done !== 1'b1) begin
                errors++;
                $display("FAIL saturation p%0d: bad=%0d c1=%0d c2=%0d done=%b, required 0/92/0/1",
                         n, bad, c1n, c2n, done);
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok, pre;
        int idle_bad;
        enable = 1'b0;
        step();
        i_ton = CNT_W'(40);
        enable = 1'b1;
        sync_start(ok);
        repeat (30) step();
        pre = o_c1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (!ok || pre !== 1'b1 ||
            {o_c1, o_c2, o_ss_done, o_period_start} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: start=%b c1_before=%b outs=%b, required 1 1 0000",
                     ok, pre, {o_c1, o_c2, o_ss_done, o_period_start});
        end
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle_bad = 0;
        repeat (10) begin
            step();
            if (o_period_start || o_c1 || o_c2) idle_bad++;
        end
        checks++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL post_reset_idle: %0d active cycles, required 0", idle_bad);
        end
        enable = 1'b1;
        step();
        checks++;
        if (o_period_start !== 1'b0) begin
            errors++;
            $display("FAIL start_latency_a: period_start=%b, required 0", o_period_start);
        end
        step();
        checks++;
        if (o_period_start !== 1'b1) begin
            errors++;
            $display("FAIL start_latency_b: period_start=%b, required 1", o_period_start);
        end
    endtask

    task automatic test_random();
        int ton, dt1, dt2, stp, m_ton, m_dt1, m_dt2, bad, gap_bad, k_chg, low1, low2;
        bit ramp, ok, prev1, prev2;
        for (int r = 0; r < 4; r++) begin
            enable = 1'b0;
            step();
            ton = $urandom_range(0, 110);
            dt1 = $urandom_range(0, 31);
            dt2 = $urandom_range(0, 31);
            stp = $urandom_range(0, 30);
            i_ton = CNT_W'(ton);
            i_dt1 = DT_W'(dt1);
            i_dt2 = DT_W'(dt2);
            i_ss_step = CNT_W'(stp);
            enable = 1'b1;
            m_dt1 = dt1;
            m_dt2 = dt2;
            ramp = !(stp == 0 || ton == 0);
            m_ton = ramp ? min_i(stp, ton) : ton;
            sync_start(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rand_start r%0d: period_start seen=%b, required 1", r, ok);
            end
            low1 = PERIOD;
            low2 = PERIOD;
            prev1 = 1'b0;
            prev2 = 1'b0;
            for (int p = 0; p < 50; p++) begin
                bad = 0;
                gap_bad = 0;
                k_chg = $urandom_range(0, PERIOD - 2);
                for (int k = 0; k < PERIOD; k++) begin
                    if (o_period_start !== (k == 0)) bad++;
                    if (o_c1 !== exp_c1(k, m_ton, m_dt1) ||
                        o_c2 !== exp_c2(k, m_ton, m_dt2)) bad++;
                    if (o_c1 && !prev1 && low2 < m_dt1) gap_bad++;
                    if (o_c2 && !prev2 && low1 < m_dt2) gap_bad++;
                    prev1 = o_c1;
                    prev2 = o_c2;
                    low1 = o_c1 ? 0 : low1 + 1;
                    low2 = o_c2 ? 0 : low2 + 1;
                    if (k == k_chg) begin
                        ton = $urandom_range(0, 110);
                        dt1 = $urandom_range(0, 31);
                        dt2 = $urandom_range(0, 31);
                        stp = $urandom_range(0, 30);
                        i_ton = CNT_W'(ton);
                        i_dt1 = DT_W'(dt1);
                        i_dt2 = DT_W'(dt2);
                        i_ss_step = CNT_W'(stp);
                    end
                    step();
                end
                checks++;
                if (bad != 0 || gap_bad != 0) begin
                    errors++;
                    $display("FAIL rand r%0d p%0d: bad=%0d gap_bad=%0d ton=%0d dt1=%0d dt2=%0d, required 0 0",
                             r, p, bad, gap_bad, m_ton, m_dt1, m_dt2);
                end
                m_dt1 = dt1;
                m_dt2 = dt2;
                if (ramp) begin
                    m_ton = min_i(m_ton + stp, ton);
                    if (m_ton == ton) ramp = 1'b0;
                end else begin
                    m_ton = ton;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_mid_change();
        test_disable();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
